// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I front end.
package rv32i_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/rv32i_fetch_buf.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; DEPTH must be a power of two >= 2.
module rv32i_fetch_buf
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  fetch_entry_t           i_wdata,
  output fetch_entry_t           o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  fetch_entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]         head_q, tail_q;
  logic [CntW-1:0]         count_q;
  logic                    do_push, do_pop;

  assign o_full  = (count_q == DepthCnt);
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_rdata = mem_q[head_q];

  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign do_push = i_push && (!o_full || i_pop);
  assign do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + PtrW'(1);
      if (do_pop)  head_q <= head_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush && do_push) begin
      mem_q[tail_q] <= i_wdata;
    end
  end

endmodule

// File: rtl/rv32i_fetch_ctrl.sv
// Instruction fetch controller: PC, fetch buffer and redirect handling.
// Optional performance counters are enabled with RV32I_FETCH_PERF_EN.
module rv32i_fetch_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned           BUF_DEPTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [INST_WIDTH-1:0] o_imem_addr,
  input  logic [INST_WIDTH-1:0] i_imem_inst,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [INST_WIDTH-1:0] o_pc,
  output logic [INST_WIDTH-1:0] o_inst,
  input  logic                  i_redirect,
  input  logic [INST_WIDTH-1:0] i_redirect_pc,
  output logic                  o_misalign
`ifdef RV32I_FETCH_PERF_EN
  ,
  output logic [31:0]           o_fetch_cnt,
  output logic [31:0]           o_stall_cnt
`endif
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;

  logic [INST_WIDTH-1:0] pc_q;
  logic                  misalign_q;
  logic                  push, pop;
  fetch_entry_t          buf_wdata, buf_rdata;
  logic [CntW-1:0]       buf_count;
  logic                  buf_full, buf_empty;
  logic                  unused_count;

  assign unused_count = ^buf_count;

  assign pop  = !buf_empty && i_ready;
  assign push = !i_redirect && (!buf_full || pop);

  assign buf_wdata.pc   = pc_q;
  assign buf_wdata.inst = i_imem_inst;

  rv32i_fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_pop   (pop),
    .i_flush (i_redirect),
    .i_wdata (buf_wdata),
    .o_rdata (buf_rdata),
    .o_count (buf_count),
    .o_full  (buf_full),
    .o_empty (buf_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else if (i_redirect) begin
      pc_q <= {i_redirect_pc[INST_WIDTH-1:2], 2'b00};
      if (i_redirect_pc[1:0] != 2'b00) misalign_q <= 1'b1;
    end else if (push) begin
      pc_q <= pc_q + INST_WIDTH'(4);
    end
  end

  assign o_imem_addr = pc_q;
  assign o_misalign  = misalign_q;
  assign o_valid     = !buf_empty;
  // The buffer's stale head is masked so decode sees a clean NOP when idle.
  assign o_pc        = buf_empty ? '0 : buf_rdata.pc;
  assign o_inst      = buf_empty ? NOP_INST : buf_rdata.inst;

`ifdef RV32I_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push)             fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (buf_full && !pop) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rv32i_fetch_ctrl.sv
// Self-checking bench for rv32i_fetch_ctrl: directed steps then random traffic vs a queue model.
module tb_rv32i_fetch_ctrl;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        i_rst, i_ready, i_redirect;
  logic [31:0] i_redirect_pc;
  logic [31:0] o_imem_addr, i_imem_inst, o_pc, o_inst;
  logic        o_valid, o_misalign;
`ifdef RV32I_FETCH_PERF_EN
  logic [31:0] o_fetch_cnt, o_stall_cnt;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign i_imem_inst = mem_word(o_imem_addr);

  rv32i_fetch_ctrl #(
    .INST_WIDTH (32),
    .RESET_PC   (RST_PC),
    .BUF_DEPTH  (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .o_imem_addr   (o_imem_addr),
    .i_imem_inst   (i_imem_inst),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_pc          (o_pc),
    .o_inst        (o_inst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_misalign    (o_misalign)
`ifdef RV32I_FETCH_PERF_EN
    ,
    .o_fetch_cnt   (o_fetch_cnt),
    .o_stall_cnt   (o_stall_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_fetch, m_stall;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] e_valid, e_pc, e_inst;
    e_valid = (mq.size() > 0) ? 32'd1 : 32'd0;
    e_pc    = (mq.size() > 0) ? mq[0].pc : 32'd0;
    e_inst  = (mq.size() > 0) ? mq[0].inst : NOP;
    check("imem_addr", o_imem_addr, m_pc);
    check("valid", {31'd0, o_valid}, e_valid);
    check("head_pc", o_pc, e_pc);
    check("head_inst", o_inst, e_inst);
    check("misalign", {31'd0, o_misalign}, {31'd0, m_mis});
`ifdef RV32I_FETCH_PERF_EN
    check("fetch_cnt", o_fetch_cnt, m_fetch);
    check("stall_cnt", o_stall_cnt, m_stall);
`endif
  endtask

  // One clock: apply inputs, advance the model by the same cycle, compare after the edge.
  task automatic step(input logic rst, input logic rdy, input logic redir,
                      input logic [31:0] rpc);
    bit pop, room;
    i_rst         = rst;
    i_ready       = rdy;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    if (rst) begin
      mq.delete();
      m_pc    = RST_PC;
      m_mis   = 1'b0;
      m_fetch = '0;
      m_stall = '0;
    end else begin
      pop  = (mq.size() > 0) && rdy;
      room = (mq.size() < DEPTH) || pop;
      if (mq.size() == DEPTH && !pop) m_stall = m_stall + 1;
      if (redir) begin
        mq.delete();
        m_pc = {rpc[31:2], 2'b00};
        if (rpc[1:0] != 2'b00) m_mis = 1'b1;
      end else begin
        if (pop) void'(mq.pop_front());
        if (room) begin
          mq.push_back('{pc: m_pc, inst: mem_word(m_pc)});
          m_pc    = m_pc + 32'd4;
          m_fetch = m_fetch + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    i_rst = 1'b1; i_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    m_pc = RST_PC; m_mis = 1'b0; m_fetch = '0; m_stall = '0;

    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_inst", o_inst, NOP);
    check("rst_addr", o_imem_addr, RST_PC);

    // Streaming from reset
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("first_pc", o_pc, 32'h0);
    check("first_inst", o_inst, 32'h1000_0000);
    check("first_addr", o_imem_addr, 32'h4);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("second_pc", o_pc, 32'h4);
    check("second_inst", o_inst, 32'h1000_0001);

    // Back-pressure starting from an empty buffer at PC 8
    step(1'b0, 1'b1, 1'b1, 32'h8);
    repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);
    check("bp_addr_hold", o_imem_addr, 32'h10);
    check("bp_head", o_pc, 32'h8);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("bp_flow1", o_pc, 32'hC);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("bp_flow2", o_pc, 32'h10);

    // Redirect with the buffer full
    step(1'b0, 1'b0, 1'b1, 32'h40);
    check("redir_valid", {31'd0, o_valid}, 32'd0);
    check("redir_addr", o_imem_addr, 32'h40);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("redir_target", o_pc, 32'h40);

    // Misaligned target
    step(1'b0, 1'b1, 1'b1, 32'h46);
    check("mis_addr", o_imem_addr, 32'h44);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    check("mis_sticky", {31'd0, o_misalign}, 32'd1);

    // Wrap at the top of the address space
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    check("wrap_target", o_imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("wrap_addr", o_imem_addr, 32'h0);
    check("wrap_head", o_pc, 32'hFFFF_FFFC);

    // Redirect together with a pop of a full buffer
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h100);
    check("rp_valid", {31'd0, o_valid}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("rp_head", o_pc, 32'h100);

    // Reset mid-stream with two entries buffered
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("mrst_valid", {31'd0, o_valid}, 32'd0);
    check("mrst_addr", o_imem_addr, RST_PC);
    check("mrst_inst", o_inst, NOP);
    check("mrst_mis", {31'd0, o_misalign}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) == 0), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
